// File: rtl/std_cache_pkg.sv
// Shared types for the std_nbdcache SRAM array: line/byte-enable layout,
// arbiter state encoding and the default starvation limit.
package std_cache_pkg;

    localparam int unsigned DCACHE_LINE_WIDTH   = 128;
    localparam int unsigned DCACHE_TAG_WIDTH    = 44;
    localparam int unsigned DCACHE_STARVE_LIMIT = 15;

    // one SRAM line: tag, data and the valid/dirty/shared status bits
    typedef struct packed {
        logic [DCACHE_TAG_WIDTH-1:0]  tag;
        logic [DCACHE_LINE_WIDTH-1:0] data;
        logic                         valid;
        logic                         dirty;
        logic                         shared;
    } cache_line_t;

    // byte enables matching cache_line_t field by field
    typedef struct packed {
        logic [(DCACHE_TAG_WIDTH+7)/8-1:0] tag;
        logic [DCACHE_LINE_WIDTH/8-1:0]    data;
        logic                              valid;
        logic                              dirty;
        logic                              shared;
    } cl_be_t;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/std_dcache_sram_arb_rr_starve_pick.sv
// Winner select for the dcache SRAM arbiter: port 0 first, then the lowest
// starved requester, then the lowest requester. Pure combinational.
module rr_starve_pick #(
    parameter int unsigned NR_PORTS = 5
) (
    input  logic [NR_PORTS-1:0]                                 req,
    input  logic [NR_PORTS-1:0]                                 starved,
    output logic [NR_PORTS-1:0]                                 gnt,
    output logic [((NR_PORTS > 1) ? $clog2(NR_PORTS) : 1)-1:0] idx,
    output logic                                                valid
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;

    // three-tier priority; the found flag keeps the lowest index in each tier
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        gnt   = '0;
        if (req[0]) begin
            valid = 1'b1;
        end
        for (int unsigned p = 1; p < NR_PORTS; p++) begin
            if (!valid && req[p] && starved[p]) begin
                valid = 1'b1;
                idx   = IDX_W'(p);
            end
        end
        for (int unsigned p = 1; p < NR_PORTS; p++) begin
            if (!valid && req[p]) begin
                valid = 1'b1;
                idx   = IDX_W'(p);
            end
        end
        if (valid) begin
            gnt[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/std_dcache_sram_arb.sv
// Shared-SRAM arbiter for std_nbdcache: starvation-bounded fixed priority,
// multi-cycle lock for miss handler / snoop, registered tag compare for hit_way.
// Optional per-port conflict counters: define STD_DCACHE_SRAM_ARB_PERF_EN.
module std_dcache_sram_arb
    import std_cache_pkg::*;
#(
    parameter int unsigned NR_PORTS     = 5,
    parameter int unsigned SET_ASSOC    = 8,
    parameter int unsigned INDEX_WIDTH  = 12,
    parameter int unsigned TAG_WIDTH    = 44,
    parameter int unsigned STARVE_LIMIT = DCACHE_STARVE_LIMIT
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NR_PORTS-1:0][SET_ASSOC-1:0]   req_i,
    input  logic [NR_PORTS-1:0]                  lock_i,
    input  logic [NR_PORTS-1:0][INDEX_WIDTH-1:0] addr_i,
    input  logic [NR_PORTS-1:0][TAG_WIDTH-1:0]   tag_i,
    input  logic [NR_PORTS-1:0]                  we_i,
    input  cache_line_t [NR_PORTS-1:0]           wdata_i,
    input  cl_be_t [NR_PORTS-1:0]                be_i,
    output logic [NR_PORTS-1:0]                  gnt_o,
    output cache_line_t [SET_ASSOC-1:0]          rdata_o,
    output logic [SET_ASSOC-1:0]                 hit_way_o,
    output logic [SET_ASSOC-1:0]                 req_ram_o,
    output logic [INDEX_WIDTH-1:0]               addr_ram_o,
    output logic                                 we_ram_o,
    output cache_line_t                          wdata_ram_o,
    output cl_be_t                               be_ram_o,
`ifdef STD_DCACHE_SRAM_ARB_PERF_EN
    output logic [NR_PORTS-1:0][31:0]            perf_conflict_o,
`endif
    input  cache_line_t [SET_ASSOC-1:0]          rdata_ram_i
);

    localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e                       state;
    logic [IDX_W-1:0]                 owner;
    logic [NR_PORTS-1:0][CNT_W-1:0]   starve_cnt;
    logic [TAG_WIDTH-1:0]             tag_q;
    logic                             rd_q;

    logic [NR_PORTS-1:0]              port_req;
    logic [NR_PORTS-1:0]              starved;
    logic [NR_PORTS-1:0]              eligible;
    logic [NR_PORTS-1:0]              pick_gnt;
    logic [IDX_W-1:0]                 winner;
    logic [IDX_W-1:0]                 sel;
    logic                             pick_valid;
    logic                             granted;

    // request/starve summaries; in LOCK only the owner is eligible
    always_comb begin
        port_req = '0;
        starved  = '0;
        for (int unsigned p = 0; p < NR_PORTS; p++) begin
            port_req[p] = |req_i[p];
            starved[p]  = (starve_cnt[p] == CNT_W'(STARVE_LIMIT));
        end
        if (state == LOCK) begin
            eligible        = '0;
            eligible[owner] = port_req[owner];
        end else begin
            eligible = port_req;
        end
    end

    rr_starve_pick #(
        .NR_PORTS (NR_PORTS)
    ) i_pick (
        .req     (eligible),
        .starved (starved),
        .gnt     (pick_gnt),
        .idx     (winner),
        .valid   (pick_valid)
    );

    // grant and SRAM mux; reset forces all requests off the SRAM
    always_comb begin
        granted     = rst_ni & pick_valid;
        gnt_o       = granted ? pick_gnt : '0;
        sel         = granted ? winner : '0;
        req_ram_o   = granted ? req_i[winner] : '0;
        we_ram_o    = granted & we_i[winner];
        addr_ram_o  = addr_i[sel];
        wdata_ram_o = wdata_i[sel];
        be_ram_o    = be_i[sel];
    end

    // ARB/LOCK sequencing; only miss handler and snoop may take the lock
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ARB;
            owner <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (granted && (winner < IDX_W'(2)) && lock_i[winner]) begin
                        state <= LOCK;
                        owner <= winner;
                    end
                end
                LOCK: begin
                    if (!lock_i[owner]) begin
                        state <= ARB;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

    // starvation counters; port 0 is always top priority so its slot stays 0
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt[0] <= '0;
            for (int unsigned p = 1; p < NR_PORTS; p++) begin
                if (port_req[p] && !gnt_o[p]) begin
                    if (starve_cnt[p] != CNT_W'(STARVE_LIMIT)) begin
                        starve_cnt[p] <= starve_cnt[p] + CNT_W'(1);
                    end
                end else begin
                    starve_cnt[p] <= '0;
                end
            end
        end
    end

    // capture the compare tag of a granted read for next-cycle hit detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q  <= 1'b0;
            tag_q <= '0;
        end else if (granted && !we_i[winner]) begin
            rd_q  <= 1'b1;
            tag_q <= tag_i[winner];
        end else begin
            rd_q  <= 1'b0;
        end
    end

    // per-way hit against the SRAM output of the previous cycle's read
    always_comb begin
        rdata_o   = rdata_ram_i;
        hit_way_o = '0;
        for (int unsigned w = 0; w < SET_ASSOC; w++) begin
            hit_way_o[w] = rd_q & rdata_ram_i[w].valid & (rdata_ram_i[w].tag == tag_q);
        end
    end

`ifdef STD_DCACHE_SRAM_ARB_PERF_EN
    logic [NR_PORTS-1:0][31:0] perf_q;

    // count cycles each port spends requesting without a grant (wrapping)
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else begin
            for (int unsigned p = 0; p < NR_PORTS; p++) begin
                if (port_req[p] && !gnt_o[p]) begin
                    perf_q[p] <= perf_q[p] + 32'd1;
                end
            end
        end
    end

    assign perf_conflict_o = perf_q;
`endif

endmodule

// File: tb/tb_std_dcache_sram_arb.sv
// Table-driven bench for std_dcache_sram_arb: one table row per clock cycle,
// plus hand-written starvation-latency and (optional) conflict-counter sequences.
module tb_std_dcache_sram_arb;
    import std_cache_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [4:0][7:0]        req_i;
    logic [4:0]             lock_i;
    logic [4:0][11:0]       addr_i;
    logic [4:0][43:0]       tag_i;
    logic [4:0]             we_i;
    cache_line_t [4:0]      wdata_i;
    cl_be_t [4:0]           be_i;
    logic [4:0]             gnt_o;
    cache_line_t [7:0]      rdata_o;
    logic [7:0]             hit_way_o;
    logic [7:0]             req_ram_o;
    logic [11:0]            addr_ram_o;
    logic                   we_ram_o;
    cache_line_t            wdata_ram_o;
    cl_be_t                 be_ram_o;
    cache_line_t [7:0]      rdata_ram_i;
`ifdef STD_DCACHE_SRAM_ARB_PERF_EN
    logic [4:0][31:0]       perf_conflict_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    std_dcache_sram_arb #(
        .NR_PORTS     (5),
        .SET_ASSOC    (8),
        .INDEX_WIDTH  (12),
        .TAG_WIDTH    (44),
        .STARVE_LIMIT (15)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_i           (req_i),
        .lock_i          (lock_i),
        .addr_i          (addr_i),
        .tag_i           (tag_i),
        .we_i            (we_i),
        .wdata_i         (wdata_i),
        .be_i            (be_i),
        .gnt_o           (gnt_o),
        .rdata_o         (rdata_o),
        .hit_way_o       (hit_way_o),
        .req_ram_o       (req_ram_o),
        .addr_ram_o      (addr_ram_o),
        .we_ram_o        (we_ram_o),
        .wdata_ram_o     (wdata_ram_o),
        .be_ram_o        (be_ram_o),
`ifdef STD_DCACHE_SRAM_ARB_PERF_EN
        .perf_conflict_o (perf_conflict_o),
`endif
        .rdata_ram_i     (rdata_ram_i)
    );

    typedef struct {
        bit          rst;
        logic [4:0]  req;
        logic [4:0]  lock;
        logic [4:0]  we;
        logic [4:0]  egnt;
        bit          ewe;
        logic [7:0]  ehit;
        logic [43:0] tag;
        int unsigned rway;
        logic [43:0] rtag;
        bit          rvalid;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(bit rst, logic [4:0] req, logic [4:0] lock, logic [4:0] we,
                                logic [4:0] egnt, bit ewe, logic [7:0] ehit,
                                logic [43:0] tag = 44'h0, int unsigned rway = 0,
                                logic [43:0] rtag = 44'h0, bit rvalid = 1'b0);
        vec_t v;
        v.rst = rst; v.req = req; v.lock = lock; v.we = we;
        v.egnt = egnt; v.ewe = ewe; v.ehit = ehit;
        v.tag = tag; v.rway = rway; v.rtag = rtag; v.rvalid = rvalid;
        vecs.push_back(v);
    endfunction

    function automatic logic [11:0] port_addr(int unsigned p);
        return 12'h0A0 + 12'(p) * 12'h111;
    endfunction

    function automatic cl_be_t port_be(int unsigned p);
        cl_be_t b;
        b       = '0;
        b.data  = 16'(16'h0003 << (2 * p));
        b.tag   = 6'(p + 1);
        b.valid = 1'b1;
        return b;
    endfunction

    function automatic cache_line_t port_line(int unsigned p);
        cache_line_t l;
        l      = '0;
        l.data = {4{32'hC0DE_0000 + 32'(p)}};
        l.tag  = 44'(p);
        return l;
    endfunction

    function automatic cache_line_t way_line(int unsigned w, vec_t v);
        cache_line_t l;
        l      = '0;
        l.data = {4{32'h5A5A_0000 + 32'(w)}};
        if (w == v.rway) begin
            l.tag   = v.rtag;
            l.valid = v.rvalid;
        end else begin
            l.tag   = v.rtag + 44'd1;
            l.valid = 1'b1;
        end
        return l;
    endfunction

    task automatic chk(string nm, int row, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst_n  = !v.rst;
        lock_i = v.lock;
        we_i   = v.we;
        for (int p = 0; p < 5; p++) begin
            req_i[p]   = v.req[p] ? 8'(8'h01 << p) : 8'h00;
            tag_i[p]   = v.tag;
            addr_i[p]  = port_addr(p);
            wdata_i[p] = port_line(p);
            be_i[p]    = port_be(p);
        end
        for (int w = 0; w < 8; w++) begin
            rdata_ram_i[w] = way_line(w, v);
        end
    endtask

    task automatic check_row(int row, vec_t v);
        int unsigned idx;
        cache_line_t wl;
        idx = 0;
        for (int p = 0; p < 5; p++) begin
            if (v.egnt[p]) idx = p;
        end
        wl = way_line(v.rway, v);
        chk("gnt", row, 128'(gnt_o), 128'(v.egnt));
        chk("req_ram", row, 128'(req_ram_o), (v.egnt != 5'b0) ? 128'(8'h01 << idx) : 128'h0);
        chk("we_ram", row, 128'(we_ram_o), 128'(v.ewe));
        chk("hit_way", row, 128'(hit_way_o), 128'(v.ehit));
        chk("rdata_tag", row, 128'(rdata_o[v.rway].tag), 128'(wl.tag));
        if (v.egnt != 5'b0) begin
            chk("addr_ram", row, 128'(addr_ram_o), 128'(port_addr(idx)));
            chk("be_ram", row, 128'(be_ram_o), 128'(port_be(idx)));
            chk("wdata_ram", row, wdata_ram_o.data, port_line(idx).data);
        end
    endtask

    task automatic set_idle();
        vec_t v;
        v = '{rst: 1'b0, req: 5'b0, lock: 5'b0, we: 5'b0, egnt: 5'b0, ewe: 1'b0,
              ehit: 8'h0, tag: 44'h0, rway: 0, rtag: 44'h0, rvalid: 1'b0};
        drive(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cyc;
        bit got;

        rst_n = 1'b0;
        set_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);

        // reset row and idle
        add(1, 5'b00100, 5'b0, 5'b0, 5'b00000, 0, 8'h00);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00);
        // load vs store: store escalated on the 16th cycle, then load resumes
        for (int i = 1; i <= 15; i++) add(0, 5'b11000, 5'b0, 5'b0, 5'b01000, 0, 8'h00);
        add(0, 5'b11000, 5'b0, 5'b0, 5'b10000, 0, 8'h00);
        add(0, 5'b11000, 5'b0, 5'b0, 5'b01000, 0, 8'h00);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00);
        // miss-handler lock: 8 beats, release on the last, then PTW
        for (int i = 1; i <= 7; i++) add(0, 5'b00101, 5'b00001, 5'b0, 5'b00001, 0, 8'h00);
        add(0, 5'b00101, 5'b00000, 5'b0, 5'b00001, 0, 8'h00);
        add(0, 5'b00100, 5'b00000, 5'b0, 5'b00100, 0, 8'h00);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00);
        // snoop lock holds off the miss handler until released
        add(0, 5'b00010, 5'b00010, 5'b0, 5'b00010, 0, 8'h00);
        add(0, 5'b00011, 5'b00010, 5'b0, 5'b00010, 0, 8'h00);
        add(0, 5'b00001, 5'b00000, 5'b0, 5'b00000, 0, 8'h00);
        add(0, 5'b00001, 5'b00000, 5'b0, 5'b00001, 0, 8'h00);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00);
        // hit detection on way 3
        add(0, 5'b00100, 5'b0, 5'b0, 5'b00100, 0, 8'h00, 44'h1A);
        add(0, 5'b00100, 5'b0, 5'b0, 5'b00100, 0, 8'h08, 44'h1A, 3, 44'h1A, 1);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00, 44'h1A, 3, 44'h1A, 0);
        add(0, 5'b00100, 5'b0, 5'b0, 5'b00100, 0, 8'h00, 44'h1A);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00, 44'h1A, 3, 44'h1B, 1);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00, 44'h1A, 3, 44'h1A, 1);
        // snoop write then idle: no hit after a write grant
        add(0, 5'b00010, 5'b0, 5'b00010, 5'b00010, 1, 8'h00, 44'h1A);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00, 44'h1A, 3, 44'h1A, 1);
        // reset in the middle of a miss-handler lock
        add(0, 5'b00101, 5'b00001, 5'b0, 5'b00001, 0, 8'h00);
        add(0, 5'b00101, 5'b00001, 5'b0, 5'b00001, 0, 8'h00);
        add(1, 5'b00101, 5'b00001, 5'b0, 5'b00000, 0, 8'h00);
        add(0, 5'b00100, 5'b00000, 5'b0, 5'b00100, 0, 8'h00, 44'h0, 3, 44'h0, 1);
        add(0, 5'b00000, 5'b0, 5'b0, 5'b00000, 0, 8'h00);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check_row(i, vecs[i]);
        end

        // PTW and store contending: store must win exactly on its 16th cycle
        @(negedge clk);
        set_idle();
        req_i[2] = 8'h04;
        req_i[4] = 8'h10;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 40) begin
            #1;
            cyc++;
            if (gnt_o[4]) got = 1'b1;
            else @(negedge clk);
        end
        chk("starve_latency", -1, 128'(cyc), 128'd16);
        @(negedge clk);
        #1;
        chk("after_starve_gnt", -1, 128'(gnt_o), 128'(5'b00100));
        @(negedge clk);
        set_idle();

`ifdef STD_DCACHE_SRAM_ARB_PERF_EN
        // store blocked by the miss handler for 10 cycles
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_i[0] = 8'h01;
        req_i[4] = 8'h10;
        repeat (10) @(negedge clk);
        set_idle();
        #1;
        chk("perf_port4", -1, 128'(perf_conflict_o[4]), 128'd10);
        chk("perf_port0", -1, 128'(perf_conflict_o[0]), 128'd0);
        chk("perf_port2", -1, 128'(perf_conflict_o[2]), 128'd0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
